// File: rtl/stutter_sched_pkg.sv
// Shared types and limits for the stutter scheduler and its round-robin picker.
// The optional bounded-stutter feature is selected by STUTTER_SCHED_FAIRNESS_EN.
package stutter_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

  localparam int NUM_COPIES_MIN  = 1;
  localparam int NUM_COPIES_MAX  = 8;
  localparam int MAX_STUTTER_MIN = 1;
  localparam int MAX_STUTTER_MAX = 15;

  // Bits needed to count 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/stutter_scheduler_rr_pick.sv
// rr_pick: combinational cyclic first-one search over req starting at ptr.
// Zero latency; vld low when no bit of req is set.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          vld
);

  int j;

  always_comb begin
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!vld && req[j]) begin
        idx = PW'(j);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stutter_scheduler.sv
// Filters free stutter choices so some unfinished copy always steps and done copies freeze.
// Outputs registered one cycle after sampling; STUTTER_SCHED_FAIRNESS_EN adds per-copy stutter bounds.
module stutter_scheduler
  import stutter_sched_pkg::*;
#(
  parameter int NUM_COPIES  = 2,
  parameter int MAX_STUTTER = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_COPIES-1:0] stutter_req,
  input  logic [NUM_COPIES-1:0] done,
  output logic [NUM_COPIES-1:0] stutter_out,
  output logic [NUM_COPIES-1:0] forced,
  output logic                  all_done
);

  localparam int PW = (NUM_COPIES > 1) ? $clog2(NUM_COPIES) : 1;

  sched_state_t          state;
  logic [PW-1:0]         ptr;
  logic [NUM_COPIES-1:0] active;
  logic [NUM_COPIES-1:0] want;
  logic [NUM_COPIES-1:0] lim;
  logic [NUM_COPIES-1:0] pre_eff;
  logic [NUM_COPIES-1:0] eff;
  logic [NUM_COPIES-1:0] forced_c;
  logic                  need_step;
  logic [PW-1:0]         pick_idx;
  logic                  pick_vld;
  logic [PW-1:0]         ptr_nxt;

  assign active  = ~done;
  assign want    = stutter_req | done;
  assign pre_eff = want & ~lim;

  rr_pick #(.N(NUM_COPIES), .PW(PW)) u_pick (
    .req (active),
    .ptr (ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Every active copy would stutter: hand the step to the next active copy in turn.
  assign need_step = pick_vld && (&(pre_eff | ~active));

  always_comb begin
    eff = pre_eff;
    if (need_step) eff[pick_idx] = 1'b0;
  end

  assign forced_c = active & stutter_req & ~eff;
  assign ptr_nxt  = (int'(pick_idx) == NUM_COPIES - 1) ? '0 : pick_idx + 1'b1;

`ifdef STUTTER_SCHED_FAIRNESS_EN
  localparam int CNT_W = cnt_width(MAX_STUTTER);

  for (genvar i = 0; i < NUM_COPIES; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (state != S_RUN || start) begin
        cnt <= '0;
      end else if (eff[i] && active[i]) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end

    assign lim[i] = active[i] && (cnt == CNT_W'(MAX_STUTTER));
  end
`else
  assign lim = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      stutter_out <= '1;
      forced      <= '0;
      all_done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          stutter_out <= '1;
          forced      <= '0;
          all_done    <= 1'b0;
          if (start) begin
            state <= S_RUN;
            ptr   <= '0;
          end
        end
        S_RUN: begin
          if (start) begin
            // Restart: freeze outputs for one cycle, first decision on the next edge.
            ptr         <= '0;
            stutter_out <= '1;
            forced      <= '0;
          end else begin
            stutter_out <= eff;
            forced      <= forced_c;
            if (need_step) ptr <= ptr_nxt;
            if (&done) begin
              state    <= S_DONE;
              all_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          stutter_out <= '1;
          forced      <= '0;
          if (start) begin
            state    <= S_RUN;
            all_done <= 1'b0;
            ptr      <= '0;
          end
        end
        default: begin
          state       <= S_IDLE;
          stutter_out <= '1;
          forced      <= '0;
          all_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
